// File: rtl/lsu_ctrl.sv
// Load/store sequencer behind ex_mem: word-aligned bus transactions,
// read-modify-write for sub-word stores, extended load write-back.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        hold_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        done_o,
    output logic        err_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic        load_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic [2:0]  f3;
    logic        is_load;
    logic        is_store;
    logic        accept;
    logic        f3_ok;
    logic        mis;
    logic [31:0] shifted;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] ext;
    logic [31:0] merged;
    logic        unused_bits;

    assign unused_bits = ^inst_i[31:15];

    assign f3       = inst_i[14:12];
    assign is_load  = inst_i[6:0] == OP_LOAD;
    assign is_store = inst_i[6:0] == OP_STORE;
    assign accept   = (state == IDLE) && start_i && (is_load || is_store);
    assign hold_o   = accept || (state == RD) || (state == WR);

    always_comb begin
        f3_ok = 1'b0;
        unique case (f3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = is_load;
            default:                f3_ok = 1'b0;
        endcase
    end

    assign mis = ((f3[1:0] == 2'b01) && addr_i[0]) ||
                 ((f3[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

    // Lane extraction works straight off the bus so the result registers on ack
    assign shifted = mem_rdata_i >> {lane_q, 3'b000};
    assign lb      = shifted[7:0];
    assign lh      = shifted[15:0];

    always_comb begin
        ext = mem_rdata_i;
        unique case (f3_q)
            3'b000:  ext = {{24{lb[7]}}, lb};
            3'b001:  ext = {{16{lh[15]}}, lh};
            3'b100:  ext = {24'd0, lb};
            3'b101:  ext = {16'd0, lh};
            default: ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        merged = mem_rdata_i;
        if (f3_q == 3'b000)
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            load_q      <= 1'b0;
            f3_q        <= 3'd0;
            rd_q        <= 5'd0;
            lane_q      <= 2'd0;
            wdata_q     <= 16'd0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= 5'd0;
            reg_wdata_o <= 32'd0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            reg_we_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        load_q     <= is_load;
                        f3_q       <= f3;
                        rd_q       <= inst_i[11:7];
                        lane_q     <= addr_i[1:0];
                        wdata_q    <= wdata_i[15:0];
                        cnt        <= '0;
                        mem_addr_o <= {addr_i[31:2], 2'b00};
                        if (!f3_ok || mis) begin
                            state <= ERR;
                            err_o <= 1'b1;
                        end else if (is_store && f3 == 3'b010) begin
                            state       <= WR;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= 1'b1;
                            mem_wdata_o <= wdata_i;
                        end else begin
                            state     <= RD;
                            mem_req_o <= 1'b1;
                            mem_we_o  <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (mem_ack_i) begin
                        if (load_q) begin
                            state       <= DONE;
                            mem_req_o   <= 1'b0;
                            done_o      <= 1'b1;
                            reg_we_o    <= rd_q != 5'd0;
                            reg_waddr_o <= rd_q;
                            reg_wdata_o <= ext;
                        end else begin
                            state       <= WR;
                            mem_we_o    <= 1'b1;
                            mem_wdata_o <= merged;
                            cnt         <= '0;
                        end
                    end else if (cnt == LIM) begin
                        state     <= ERR;
                        mem_req_o <= 1'b0;
                        err_o     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR: begin
                    if (mem_ack_i) begin
                        state     <= DONE;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        done_o    <= 1'b1;
                    end else if (cnt == LIM) begin
                        state     <= ERR;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        err_o     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    reg_waddr_o <= 5'd0;
                    reg_wdata_o <= 32'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a short bus timeout.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] inst_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        hold_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        done_o;
    logic        err_o;

    int tests = 0;
    int fails = 0;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .inst_i(inst_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i), .hold_o(hold_o), .reg_we_o(reg_we_o),
        .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op,
                                       input logic [2:0] f3,
                                       input logic [4:0] rd);
        return {17'd0, f3, rd, op};
    endfunction

    task automatic issue(input logic [31:0] inst, input logic [31:0] a,
                         input logic [31:0] wd, input string tag);
        start_i = 1'b1;
        inst_i  = inst;
        addr_i  = a;
        wdata_i = wd;
        #1;
        chk({tag, ".hold_accept"}, 32'(hold_o), 32'd1);
        tick();
        start_i = 1'b0;
        inst_i  = '0;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] exp, input string tag);
        issue(mk(LD, f3, rd), a, 32'd0, tag);
        chk({tag, ".req"}, 32'(mem_req_o), 32'd1);
        chk({tag, ".we"}, 32'(mem_we_o), 32'd0);
        chk({tag, ".addr"}, mem_addr_o, {a[31:2], 2'b00});
        mem_ack_i   = 1'b1;
        mem_rdata_i = rdata;
        tick();
        mem_ack_i = 1'b0;
        chk({tag, ".reg_we"}, 32'(reg_we_o), 32'(rd != 5'd0));
        chk({tag, ".waddr"}, 32'(reg_waddr_o), 32'(rd));
        chk({tag, ".wdata"}, reg_wdata_o, exp);
        chk({tag, ".done"}, 32'(done_o), 32'd1);
        chk({tag, ".req_drop"}, 32'(mem_req_o), 32'd0);
        chk({tag, ".hold_done"}, 32'(hold_o), 32'd0);
        tick();
        chk({tag, ".done_pulse"}, 32'(done_o), 32'd0);
        chk({tag, ".we_pulse"}, 32'(reg_we_o), 32'd0);
    endtask

    task automatic do_sub_store(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd,
                                input logic [31:0] mem,
                                input logic [31:0] exp, input string tag);
        issue(mk(ST, f3, 5'd0), a, wd, tag);
        chk({tag, ".rd_req"}, 32'(mem_req_o), 32'd1);
        chk({tag, ".rd_we"}, 32'(mem_we_o), 32'd0);
        chk({tag, ".rd_addr"}, mem_addr_o, {a[31:2], 2'b00});
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem;
        tick();
        mem_ack_i = 1'b0;
        chk({tag, ".wr_req"}, 32'(mem_req_o), 32'd1);
        chk({tag, ".wr_we"}, 32'(mem_we_o), 32'd1);
        chk({tag, ".wr_addr"}, mem_addr_o, {a[31:2], 2'b00});
        chk({tag, ".wr_data"}, mem_wdata_o, exp);
        tick();
        chk({tag, ".wr_stable"}, mem_wdata_o, exp);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk({tag, ".done"}, 32'(done_o), 32'd1);
        chk({tag, ".no_reg_we"}, 32'(reg_we_o), 32'd0);
        chk({tag, ".req_drop"}, 32'(mem_req_o), 32'd0);
        tick();
    endtask

    task automatic do_err(input logic [31:0] inst, input logic [31:0] a,
                          input string tag);
        issue(inst, a, 32'h0, tag);
        chk({tag, ".err"}, 32'(err_o), 32'd1);
        chk({tag, ".req"}, 32'(mem_req_o), 32'd0);
        chk({tag, ".hold"}, 32'(hold_o), 32'd0);
        chk({tag, ".done"}, 32'(done_o), 32'd0);
        tick();
        chk({tag, ".err_pulse"}, 32'(err_o), 32'd0);
        chk({tag, ".req_after"}, 32'(mem_req_o), 32'd0);
        chk({tag, ".hold_after"}, 32'(hold_o), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst.req", 32'(mem_req_o), 32'd0);
        chk("rst.we", 32'(mem_we_o), 32'd0);
        chk("rst.addr", mem_addr_o, 32'd0);
        chk("rst.wdata", mem_wdata_o, 32'd0);
        chk("rst.hold", 32'(hold_o), 32'd0);
        chk("rst.reg_we", 32'(reg_we_o), 32'd0);
        chk("rst.rdata", reg_wdata_o, 32'd0);
        chk("rst.done", 32'(done_o), 32'd0);
        chk("rst.err", 32'(err_o), 32'd0);
        rst = 1'b0;
        tick();

        // LW with ack two cycles after the request rises
        issue(mk(LD, 3'b010, 5'd5), 32'h100, 32'd0, "lw");
        chk("lw.req", 32'(mem_req_o), 32'd1);
        chk("lw.addr", mem_addr_o, 32'h100);
        tick();
        chk("lw.hold_wait", 32'(hold_o), 32'd1);
        tick();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hDEADBEEF;
        tick();
        mem_ack_i = 1'b0;
        chk("lw.reg_we", 32'(reg_we_o), 32'd1);
        chk("lw.waddr", 32'(reg_waddr_o), 32'd5);
        chk("lw.wdata", reg_wdata_o, 32'hDEADBEEF);
        chk("lw.done", 32'(done_o), 32'd1);
        tick();
        chk("lw.done_pulse", 32'(done_o), 32'd0);

        do_load(3'b000, 32'h103, 5'd1, 32'h80123456, 32'hFFFFFF80, "lb");
        do_load(3'b100, 32'h103, 5'd2, 32'h80123456, 32'h00000080, "lbu");
        do_load(3'b001, 32'h102, 5'd3, 32'h80123456, 32'hFFFF8012, "lh");
        do_load(3'b101, 32'h100, 5'd4, 32'h80123456, 32'h00003456, "lhu");
        do_load(3'b000, 32'h101, 5'd6, 32'h80123456, 32'h00000034, "lb1");
        do_load(3'b010, 32'h104, 5'd0, 32'hCAFEF00D, 32'hCAFEF00D, "lw_x0");

        do_sub_store(3'b000, 32'h101, 32'h000000AA, 32'h11223344,
                     32'h1122AA44, "sb");
        do_sub_store(3'b001, 32'h102, 32'h0000BEEF, 32'h11223344,
                     32'hBEEF3344, "sh");

        do_err(mk(ST, 3'b001, 5'd0), 32'h101, "sh_mis");
        do_err(mk(LD, 3'b010, 5'd7), 32'h102, "lw_mis");
        do_err(mk(LD, 3'b011, 5'd7), 32'h100, "ld_badf3");
        do_err(mk(ST, 3'b100, 5'd0), 32'h100, "st_badf3");

        // Non-memory opcode is ignored
        start_i = 1'b1;
        inst_i  = mk(7'b0010011, 3'b000, 5'd1);
        #1;
        chk("alu.hold", 32'(hold_o), 32'd0);
        tick();
        start_i = 1'b0;
        chk("alu.req", 32'(mem_req_o), 32'd0);
        chk("alu.err", 32'(err_o), 32'd0);

        // Timeout without ack
        issue(mk(LD, 3'b010, 5'd8), 32'h200, 32'd0, "to");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to.req%0d", i), 32'(mem_req_o), 32'd1);
            tick();
        end
        chk("to.err", 32'(err_o), 32'd1);
        chk("to.req_drop", 32'(mem_req_o), 32'd0);
        chk("to.no_we", 32'(reg_we_o), 32'd0);
        tick();

        // Ack on the limit cycle wins over the timeout
        issue(mk(LD, 3'b010, 5'd9), 32'h204, 32'd0, "to_ack");
        for (int i = 0; i < 7; i++) tick();
        chk("to_ack.req8", 32'(mem_req_o), 32'd1);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0BADCAFE;
        tick();
        mem_ack_i = 1'b0;
        chk("to_ack.done", 32'(done_o), 32'd1);
        chk("to_ack.err", 32'(err_o), 32'd0);
        chk("to_ack.wdata", reg_wdata_o, 32'h0BADCAFE);
        tick();

        // Reset in the middle of a SW write
        issue(mk(ST, 3'b010, 5'd0), 32'h300, 32'h12345678, "sw");
        chk("sw.req", 32'(mem_req_o), 32'd1);
        chk("sw.we", 32'(mem_we_o), 32'd1);
        chk("sw.wdata", mem_wdata_o, 32'h12345678);
        chk("sw.addr", mem_addr_o, 32'h300);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("sw_rst.req", 32'(mem_req_o), 32'd0);
        chk("sw_rst.hold", 32'(hold_o), 32'd0);
        chk("sw_rst.done", 32'(done_o), 32'd0);
        chk("sw_rst.err", 32'(err_o), 32'd0);
        tick();
        chk("sw_rst.done2", 32'(done_o), 32'd0);
        do_load(3'b010, 32'h108, 5'd10, 32'h01020304, 32'h01020304, "lw_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
